// File: rtl/mem_subsystem_cache.sv
// Direct-mapped cache (one word per line) in front of a latency-modelled backing word memory.
// WRITE_BACK selects write-back/write-allocate (1) or write-through/no-write-allocate (0).
module mem_subsystem_cache #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_DEPTH_W = 8,
    parameter int INDEX_W     = 4,
    parameter int MISS_LAT    = 8,
    parameter int WRITE_BACK  = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LOAD,
    input  logic              STORE,
    input  logic [ADDR_W-1:0] input_address,
    input  logic [DATA_W-1:0] input_data,
    output logic [DATA_W-1:0] data,
    output logic              load_done,
    output logic              store_completed,
    output logic              busy,
    output logic              hit,
    output logic [15:0]       miss_count
);
    localparam int TAG_W = MEM_DEPTH_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << MEM_DEPTH_W;
    localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MISS_LAT - 1);
    localparam logic [15:0] POR_KEY = 16'hA5C3;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, WT, RESP} state_e;

    state_e                 state_q, state_d;
    logic [MEM_DEPTH_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   is_store_q, is_store_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   load_done_q, load_done_d;
    logic                   store_completed_q, store_completed_d;
    logic [15:0]            miss_count_q, miss_count_d;
    logic [15:0]            por_key_q;
    logic [WORDS-1:0]       written_q, written_d;

    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] line_q [LINES];
    logic [DATA_W-1:0] mem_q  [WORDS];

    logic [INDEX_W-1:0]     idx;
    logic [TAG_W-1:0]       cur_tag;
    logic                   lookup_hit;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   cache_we, cache_dirty;
    logic [DATA_W-1:0]      cache_line;
    logic                   mem_we;
    logic [MEM_DEPTH_W-1:0] mem_waddr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^input_address[ADDR_W-1:MEM_DEPTH_W];
    assign idx        = addr_q[INDEX_W-1:0];
    assign cur_tag    = addr_q[MEM_DEPTH_W-1:INDEX_W];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == cur_tag);
    // Words never written since power-up read back as their own address.
    assign mem_rdata  = written_q[addr_q] ? mem_q[addr_q] : DATA_W'(addr_q);

    assign data            = data_q;
    assign load_done       = load_done_q;
    assign store_completed = store_completed_q;
    assign busy            = (state_q != IDLE);
    assign hit             = (state_q == LOOKUP) && lookup_hit;
    assign miss_count      = miss_count_q;

    // Handshake: LOAD/STORE are levels sampled only in IDLE; the request is held until
    // its one-cycle load_done/store_completed pulse, and a level still high in IDLE is a new request.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        is_store_d        = is_store_q;
        cnt_d             = cnt_q;
        data_d            = data_q;
        load_done_d       = 1'b0;
        store_completed_d = 1'b0;
        miss_count_d      = miss_count_q;
        cache_we          = 1'b0;
        cache_dirty       = 1'b0;
        cache_line        = wdata_q;
        mem_we            = 1'b0;
        mem_waddr         = addr_q;
        mem_wdata         = wdata_q;
        case (state_q)
            IDLE: begin
                if (LOAD || STORE) begin
                    state_d    = LOOKUP;
                    addr_d     = input_address[MEM_DEPTH_W-1:0];
                    wdata_d    = input_data;
                    is_store_d = STORE && !LOAD;
                end
            end
            LOOKUP: begin
                if (!lookup_hit && (miss_count_q != 16'hFFFF)) begin
                    miss_count_d = miss_count_q + 16'd1;
                end
                if (is_store_q && (WRITE_BACK == 0)) begin
                    cache_we = lookup_hit;
                    state_d  = WT;
                    cnt_d    = LAT_INIT;
                end else if (lookup_hit) begin
                    cache_we    = is_store_q;
                    cache_dirty = 1'b1;
                    state_d     = RESP;
                end else if ((WRITE_BACK != 0) && valid_q[idx] && dirty_q[idx]) begin
                    state_d = WB;
                    cnt_d   = LAT_INIT;
                end else begin
                    state_d = FILL;
                    cnt_d   = LAT_INIT;
                end
            end
            WB: begin
                if (cnt_q == '0) begin
                    mem_we    = 1'b1;
                    mem_waddr = {tag_q[idx], idx};
                    mem_wdata = line_q[idx];
                    state_d   = FILL;
                    cnt_d     = LAT_INIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FILL: begin
                if (cnt_q == '0) begin
                    // A store miss merges its data into the freshly installed line.
                    cache_we    = 1'b1;
                    cache_line  = is_store_q ? wdata_q : mem_rdata;
                    cache_dirty = is_store_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WT: begin
                if (cnt_q == '0) begin
                    mem_we  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (is_store_q) begin
                    store_completed_d = 1'b1;
                end else begin
                    load_done_d = 1'b1;
                    data_d      = line_q[idx];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        written_d = written_q;
        if (!RST_N) begin
            if (por_key_q == POR_KEY) begin
                written_d = written_q;
            end else begin
                written_d = '0;
            end
        end else if (mem_we) begin
            written_d[mem_waddr] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            wdata_q           <= '0;
            is_store_q        <= 1'b0;
            cnt_q             <= '0;
            data_q            <= '0;
            load_done_q       <= 1'b0;
            store_completed_q <= 1'b0;
            miss_count_q      <= '0;
            por_key_q         <= POR_KEY;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            wdata_q           <= wdata_d;
            is_store_q        <= is_store_d;
            cnt_q             <= cnt_d;
            data_q            <= data_d;
            load_done_q       <= load_done_d;
            store_completed_q <= store_completed_d;
            miss_count_q      <= miss_count_d;
        end
    end

    always_ff @(posedge CLK) begin
        written_q <= written_d;
        if (RST_N && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (cache_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= cache_dirty;
            tag_q[idx]   <= cur_tag;
            line_q[idx]  <= cache_line;
        end
    end
endmodule

// File: tb/tb_mem_subsystem_cache.sv
// Bench for mem_subsystem_cache: a write-back and a write-through instance checked against
// an address-level reference model (directed plan steps, mid-operation reset, random traffic).
module tb_mem_subsystem_cache;
    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        wb_rst_n, wt_rst_n;
    logic        wb_load, wb_store, wt_load, wt_store;
    logic [31:0] wb_addr, wb_wdata, wt_addr, wt_wdata;
    logic [31:0] wb_data, wt_data;
    logic        wb_load_done, wb_store_completed, wb_busy, wb_hit;
    logic        wt_load_done, wt_store_completed, wt_busy, wt_hit;
    logic [15:0] wb_miss_count, wt_miss_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // reference model: backing memory plus which address each slot holds (-1 = empty)
    logic [31:0] m_mem   [2][256];
    int          m_line  [2][16];
    logic [31:0] m_val   [2][16];
    bit          m_dirty [2][16];
    int          m_miss  [2];

    mem_subsystem_cache #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH_W(8), .INDEX_W(4),
                          .MISS_LAT(LAT), .WRITE_BACK(1)) u_wb (
        .CLK(clk), .RST_N(wb_rst_n), .LOAD(wb_load), .STORE(wb_store),
        .input_address(wb_addr), .input_data(wb_wdata), .data(wb_data),
        .load_done(wb_load_done), .store_completed(wb_store_completed),
        .busy(wb_busy), .hit(wb_hit), .miss_count(wb_miss_count)
    );

    mem_subsystem_cache #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH_W(8), .INDEX_W(4),
                          .MISS_LAT(LAT), .WRITE_BACK(0)) u_wt (
        .CLK(clk), .RST_N(wt_rst_n), .LOAD(wt_load), .STORE(wt_store),
        .input_address(wt_addr), .input_data(wt_wdata), .data(wt_data),
        .load_done(wt_load_done), .store_completed(wt_store_completed),
        .busy(wt_busy), .hit(wt_hit), .miss_count(wt_miss_count)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] o_data(input int s);
        return (s == 0) ? wb_data : wt_data;
    endfunction
    function automatic logic o_hit(input int s);
        return (s == 0) ? wb_hit : wt_hit;
    endfunction
    function automatic logic o_ld(input int s);
        return (s == 0) ? wb_load_done : wt_load_done;
    endfunction
    function automatic logic o_st(input int s);
        return (s == 0) ? wb_store_completed : wt_store_completed;
    endfunction
    function automatic logic o_busy(input int s);
        return (s == 0) ? wb_busy : wt_busy;
    endfunction
    function automatic logic [15:0] o_miss(input int s);
        return (s == 0) ? wb_miss_count : wt_miss_count;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int s);
        for (int i = 0; i < 16; i++) begin
            m_line[s][i]  = -1;
            m_dirty[s][i] = 1'b0;
            m_val[s][i]   = '0;
        end
        m_miss[s] = 0;
    endtask

    // Expected latency, hit flag and load data of one request; updates the model state.
    task automatic model(input int s, input bit ld, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output bit h, output logic [31:0] dat);
        int wa;
        int idx;
        wa  = int'(a[7:0]);
        idx = wa % 16;
        h   = (m_line[s][idx] == wa);
        dat = '0;
        if (!h && m_miss[s] < 65535) m_miss[s]++;
        if (ld || s == 0) begin
            lat = 2;
            if (!h) begin
                lat = 2 + LAT;
                if (m_line[s][idx] >= 0 && m_dirty[s][idx]) begin
                    m_mem[s][m_line[s][idx]] = m_val[s][idx];
                    lat = lat + LAT;
                end
                m_line[s][idx]  = wa;
                m_val[s][idx]   = m_mem[s][wa];
                m_dirty[s][idx] = 1'b0;
            end
            if (ld) begin
                dat = m_val[s][idx];
            end else begin
                m_val[s][idx]   = d;
                m_dirty[s][idx] = 1'b1;
            end
        end else begin
            lat = 2 + LAT;
            if (h) m_val[s][idx] = d;
            m_mem[s][wa] = d;
        end
    endtask

    // driver tasks
    task automatic drive(input int s, input bit ld, input bit st, input logic [31:0] a,
                         input logic [31:0] d);
        if (s == 0) begin
            wb_load = ld; wb_store = st; wb_addr = a; wb_wdata = d;
        end else begin
            wt_load = ld; wt_store = st; wt_addr = a; wt_wdata = d;
        end
    endtask

    task automatic req(input int s, input bit ld, input bit st, input logic [31:0] a,
                       input logic [31:0] d, output int obs_lat, output logic [31:0] obs_data);
        int          exp_lat;
        bit          exp_hit;
        logic [31:0] exp_data;
        bit          hit_seen, got_ld, got_st;
        model(s, ld, a, d, exp_lat, exp_hit, exp_data);
        if (ld) exp_q.push_back(exp_data);
        drive(s, ld, st, a, d);
        @(posedge clk); #1;
        hit_seen = o_hit(s);
        got_ld   = 1'b0;
        got_st   = 1'b0;
        obs_lat  = 0;
        while (!(got_ld || got_st) && obs_lat < 64) begin
            @(posedge clk); #1;
            obs_lat++;
            got_ld = o_ld(s);
            got_st = o_st(s);
        end
        drive(s, 1'b0, 1'b0, a, d);
        obs_data = o_data(s);
        chk("latency", 32'(obs_lat), 32'(exp_lat));
        chk("hit_pulse", 32'(hit_seen), 32'(exp_hit));
        chk("load_done", 32'(got_ld), 32'(ld));
        chk("store_completed", 32'(got_st), 32'(!ld));
        if (ld) chk("load_data", obs_data, exp_q.pop_front());
        chk("miss_count", 32'(o_miss(s)), 32'(m_miss[s]));
        chk("busy_after_done", 32'(o_busy(s)), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'({o_ld(s), o_st(s)}), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] dat;
        bit          any_pulse;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) m_mem[s][i] = 32'(i);
            model_reset(s);
        end
        wb_rst_n = 1'b0;
        wt_rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_data", o_data(s), 32'h0);
            chk("rst_done", 32'({o_ld(s), o_st(s)}), 32'd0);
            chk("rst_busy_hit", 32'({o_busy(s), o_hit(s)}), 32'd0);
            chk("rst_miss", 32'(o_miss(s)), 32'd0);
        end
        wb_rst_n = 1'b1;
        wt_rst_n = 1'b1;
        @(posedge clk); #1;

        // write-back instance: directed plan steps
        req(0, 1'b1, 1'b0, 32'h08, 32'h0, lat, dat);
        chk("tp_cold_lat", 32'(lat), 32'd10);
        chk("tp_cold_data", dat, 32'h8);
        chk("tp_cold_miss", 32'(wb_miss_count), 32'd1);
        req(0, 1'b1, 1'b0, 32'h08, 32'h0, lat, dat);
        chk("tp_hit_lat", 32'(lat), 32'd2);
        chk("tp_hit_miss", 32'(wb_miss_count), 32'd1);
        req(0, 1'b0, 1'b1, 32'h19, 32'hDEADBEEF, lat, dat);
        chk("tp_store_lat", 32'(lat), 32'd10);
        req(0, 1'b1, 1'b0, 32'h19, 32'h0, lat, dat);
        chk("tp_store_hit_lat", 32'(lat), 32'd2);
        chk("tp_store_hit_data", dat, 32'hDEADBEEF);
        req(0, 1'b1, 1'b0, 32'h29, 32'h0, lat, dat);
        chk("tp_dirty_lat", 32'(lat), 32'd18);
        chk("tp_dirty_data", dat, 32'h29);
        req(0, 1'b1, 1'b0, 32'h19, 32'h0, lat, dat);
        chk("tp_wb_lat", 32'(lat), 32'd10);
        chk("tp_wb_data", dat, 32'hDEADBEEF);
        req(0, 1'b1, 1'b1, 32'h04, 32'hFFFFFFFF, lat, dat);
        chk("tp_both_lat", 32'(lat), 32'd10);
        chk("tp_both_data", dat, 32'h4);
        req(0, 1'b1, 1'b0, 32'h04, 32'h0, lat, dat);
        chk("tp_both_reload", dat, 32'h4);

        // write-through instance
        req(1, 1'b0, 1'b1, 32'h20, 32'h12345678, lat, dat);
        chk("tp_wt_store_lat", 32'(lat), 32'd10);
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, lat, dat);
        chk("tp_wt_load_lat", 32'(lat), 32'd10);
        chk("tp_wt_load_data", dat, 32'h12345678);

        // reset during the write-back of a dirty victim
        req(0, 1'b0, 1'b1, 32'h35, 32'hCAFEF00D, lat, dat);
        drive(0, 1'b1, 1'b0, 32'h45, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_in_wb", 32'(wb_busy), 32'd1);
        @(posedge clk); #1;
        wb_rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        wb_rst_n = 1'b1;
        model_reset(0);
        chk("abort_busy", 32'(wb_busy), 32'd0);
        chk("abort_data", wb_data, 32'h0);
        chk("abort_miss", 32'(wb_miss_count), 32'd0);
        any_pulse = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            any_pulse = any_pulse | wb_load_done | wb_store_completed | wb_busy;
        end
        chk("abort_quiet", 32'(any_pulse), 32'd0);
        req(0, 1'b1, 1'b0, 32'h35, 32'h0, lat, dat);
        chk("abort_victim_lat", 32'(lat), 32'd10);
        chk("abort_victim_data", dat, 32'h35);
        req(0, 1'b1, 1'b0, 32'h45, 32'h0, lat, dat);
        chk("abort_target_data", dat, 32'h45);

        // random traffic on a small address pool to force index conflicts
        for (int i = 0; i < 80; i++) begin
            int          s;
            int          op;
            logic [31:0] a;
            logic [31:0] d;
            s      = $urandom_range(0, 1);
            op     = $urandom_range(0, 4);
            a      = $urandom();
            a[7:0] = 8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
            d      = $urandom();
            req(s, (op < 2) || (op == 4), op >= 2, a, d, lat, dat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
